// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary converter.
// Digit validation lives in the top, behind BCD_TO_BINARY_DIGIT_CHECK_EN.
package bcd_pkg;

   localparam int NUM_DIGITS = 3;
   localparam int BCD_W      = 12;
   localparam int BIN_W      = 10;
   localparam int ITERATIONS = 10;
   localparam int SR_W       = BCD_W + BIN_W;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic has_bad_digit(
      input logic [BCD_W-1:0] v
   );
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble digit correction: fields >= 8 lose 3.
// Purely combinational; instantiated once per BCD digit.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to binary converter (reverse double-dabble, 10 cycles).
// Define BCD_TO_BINARY_DIGIT_CHECK_EN to flag input digits above 9 via err.
module bcd_to_binary_seq
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BCD_W-1:0] bcd,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic [BIN_W-1:0] bin,
   output logic             err
);

   state_t           state;
   state_t           state_nx;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  shifted;
   logic [SR_W-1:0]  adjusted;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             last;

   assign shifted = sr >> 1;
   assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit_adjust u_adj (
         .d (shifted[BIN_W + 4*g +: 4]),
         .q (adjusted[BIN_W + 4*g +: 4])
      );
   end

   assign ready = ~busy;
   assign load  = start & ready;
   assign last  = (cnt == CNT_W'(ITERATIONS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = CONV;
         CONV: if (last) state_nx = DONE;
         DONE: state_nx = start ? CONV : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      valid = 1'b0;
      unique case (state)
         CONV: busy = 1'b1;
         DONE: valid = 1'b1;
         default: ;
      endcase
   end

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
   logic err_pend;
   logic err_q;

   // Bad digits still run the full latency so timing is data-independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr       <= '0;
         cnt      <= '0;
         bin      <= '0;
         err_pend <= 1'b0;
         err_q    <= 1'b0;
      end else if (load) begin
         sr       <= {bcd, {BIN_W{1'b0}}};
         cnt      <= '0;
         err_pend <= has_bad_digit(bcd);
      end else if (state == CONV) begin
         sr <= adjusted;
         if (last) begin
            bin   <= err_pend ? '0 : adjusted[BIN_W-1:0];
            err_q <= err_pend;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign err = err_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
         bin <= '0;
      end else if (load) begin
         sr  <= {bcd, {BIN_W{1'b0}}};
         cnt <= '0;
      end else if (state == CONV) begin
         sr <= adjusted;
         if (last) begin
            bin <= adjusted[BIN_W-1:0];
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq.
// Digit-check scenario follows BCD_TO_BINARY_DIGIT_CHECK_EN.
module tb_bcd_to_binary_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] bcd;
   logic        ready;
   logic        busy;
   logic        valid;
   logic [9:0]  bin;
   logic        err;

   int tests_run;
   int failures;

   bcd_to_binary_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd   (bcd),
      .ready (ready),
      .busy  (busy),
      .valid (valid),
      .bin   (bin),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns at the negedge right after the accepting edge.
   task automatic start_pulse(input logic [11:0] v);
      @(negedge clk);
      bcd   = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // n = negedges after the accepting one until valid (-1 on timeout).
   task automatic wait_valid(output int n, output bit saw_ready);
      n = -1;
      saw_ready = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (valid) begin
            n = i;
            break;
         end
         if (ready) saw_ready = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      bcd   = 12'h999;
      repeat (3) @(negedge clk);
      tests_run++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", ready);
      end
      tests_run++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy_valid got=%b%b exp=00",
                  busy, valid);
      end
      tests_run++;
      if (bin !== 10'd0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_bin_err got=%0d/%b exp=0/0",
                  bin, err);
      end
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [11:0] vin [4];
      logic [9:0]  vexp [4];
      int          n;
      bit          sr;
      vin[0] = 12'h000; vexp[0] = 10'd0;
      vin[1] = 12'h999; vexp[1] = 10'd999;
      vin[2] = 12'h255; vexp[2] = 10'd255;
      vin[3] = 12'h128; vexp[3] = 10'd128;
      for (int i = 0; i < 4; i++) begin
         start_pulse(vin[i]);
         tests_run++;
         if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy[%0d] got=%b%b exp=10",
                     i, busy, ready);
         end
         wait_valid(n, sr);
         tests_run++;
         if (n !== 10) begin
            failures++;
            $display("FAIL basic_lat[%0d] got=%0d exp=10", i, n);
         end
         tests_run++;
         if (bin !== vexp[i] || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_bin[%0d] got=%0d/%b exp=%0d/0",
                     i, bin, err, vexp[i]);
         end
         @(negedge clk);
         tests_run++;
         if (valid !== 1'b0 || ready !== 1'b1 ||
             bin !== vexp[i]) begin
            failures++;
            $display("FAIL basic_after[%0d] got=%b%b/%0d exp=01/%0d",
                     i, valid, ready, bin, vexp[i]);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int       nval;
      logic [9:0] got;
      bit       rdy;
      nval = 0;
      got  = '0;
      rdy  = 1'b0;
      start_pulse(12'h042);
      for (int i = 1; i <= 25; i++) begin
         if (i == 3) begin
            bcd   = 12'h777;
            start = 1'b1;
         end
         if (i == 4) start = 1'b0;
         @(negedge clk);
         if (i < 10 && ready) rdy = 1'b1;
         if (valid) begin
            nval++;
            got = bin;
         end
      end
      tests_run++;
      if (nval !== 1 || got !== 10'd42) begin
         failures++;
         $display("FAIL ignore_busy got=%0d valids bin=%0d exp=1/42",
                  nval, got);
      end
      tests_run++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_ready got=%b exp=0", rdy);
      end
   endtask

   task automatic test_back_to_back();
      int         t1, t2;
      logic [9:0] b1, b2;
      t1 = -1; t2 = -1;
      b1 = '0; b2 = '0;
      @(negedge clk);
      bcd   = 12'h500;
      start = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         if (i == 0) bcd = 12'h013;
         if (t1 >= 0 && i == t1 + 1) start = 1'b0;
         if (valid) begin
            if (t1 < 0) begin
               t1 = i;
               b1 = bin;
            end else if (t2 < 0) begin
               t2 = i;
               b2 = bin;
            end
         end
      end
      start = 1'b0;
      tests_run++;
      if (t1 < 0 || t2 < 0 || t2 - t1 !== 11) begin
         failures++;
         $display("FAIL b2b_gap got=%0d,%0d exp=gap 11", t1, t2);
      end
      tests_run++;
      if (b1 !== 10'd500 || b2 !== 10'd13) begin
         failures++;
         $display("FAIL b2b_bin got=%0d,%0d exp=500,13", b1, b2);
      end
   endtask

   task automatic test_reset_mid();
      int nval;
      int n;
      bit sr;
      nval = 0;
      start_pulse(12'h654);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (ready !== 1'b1 || busy !== 1'b0 || bin !== 10'd0) begin
         failures++;
         $display("FAIL rstmid_state got=%b%b/%0d exp=10/0",
                  ready, busy, bin);
      end
      for (int i = 0; i < 15; i++) begin
         if (valid) nval++;
         @(negedge clk);
      end
      tests_run++;
      if (nval !== 0) begin
         failures++;
         $display("FAIL rstmid_novalid got=%0d exp=0", nval);
      end
      start_pulse(12'h321);
      wait_valid(n, sr);
      tests_run++;
      if (n !== 10 || bin !== 10'd321) begin
         failures++;
         $display("FAIL rstmid_next got=%0d/%0d exp=10/321", n, bin);
      end
   endtask

   task automatic test_digit_check();
      int n;
      bit sr;
      start_pulse(12'h1A0);
      wait_valid(n, sr);
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
      tests_run++;
      if (n !== 10 || err !== 1'b1 || bin !== 10'd0) begin
         failures++;
         $display("FAIL dchk_bad got=%0d/%b/%0d exp=10/1/0",
                  n, err, bin);
      end
`else
      tests_run++;
      if (n !== 10 || err !== 1'b0 || bin !== 10'd200) begin
         failures++;
         $display("FAIL dchk_raw got=%0d/%b/%0d exp=10/0/200",
                  n, err, bin);
      end
`endif
      start_pulse(12'h100);
      wait_valid(n, sr);
      tests_run++;
      if (n !== 10 || err !== 1'b0 || bin !== 10'd100) begin
         failures++;
         $display("FAIL dchk_good got=%0d/%b/%0d exp=10/0/100",
                  n, err, bin);
      end
   endtask

   initial begin
      tests_run = 0;
      failures  = 0;
      rst   = 1'b1;
      start = 1'b0;
      bcd   = '0;
      test_reset();
      test_basic();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_digit_check();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
